proc_fetch_queue: RTL and testbench

Instruction fetch queue between the fetch stage and the decode stage. It buffers up to DEPTH fetched words, each with its PC+2 value and fetch-error flag. Decode can stall without throttling instruction memory every cycle. A flush discards all buffered entries on a taken branch or jump.

---
 rtl/proc_fetch_queue.sv | 97 +++++++++
 tb/tb_proc_fetch_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/proc_fetch_queue.sv
// Instruction fetch queue between fetch and decode: DEPTH entries of {err, incpc, instr}.
// Optional feature: define FETCH_QUEUE_BYPASS_EN for zero-latency forwarding through an empty queue.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// The producer holds its data stable while valid=1 and ready=0.
// ready may depend on valid only through the documented bypass path.
module proc_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [15:0]   in_instr,
  input  logic [15:0]   in_incpc,
  input  logic          in_err,
  output logic          in_ready,
  output logic          out_valid,
  output logic [15:0]   out_instr,
  output logic [15:0]   out_incpc,
  output logic          out_err,
  input  logic          out_ready,
  input  logic          flush,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ZERO_CNT = '0;

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;

  logic          byp_act;
  logic          byp_take;
  logic          wr_en;
  logic          rd_en;
  logic [32:0]   head;

  // Bypass is only live out of reset, with an empty queue and no flush pending.
`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp_act = rst && (cnt == ZERO_CNT) && !flush;
`else
  assign byp_act = 1'b0;
`endif

  assign head     = mem[rd_ptr];
  assign in_ready = rst && !flush && (cnt != FULL_CNT);

  always_comb begin
    out_valid = (cnt != ZERO_CNT);
    out_instr = head[15:0];
    out_incpc = head[31:16];
    out_err   = head[32];
    if (byp_act) begin
      out_valid = in_valid;
      out_instr = in_instr;
      out_incpc = in_incpc;
      out_err   = in_err;
    end
  end

  // A bypassed word that decode takes in the same cycle never touches storage.
  assign byp_take = byp_act && in_valid && out_ready;
  assign wr_en    = in_valid && in_ready && !byp_take;
  assign rd_en    = out_ready && (cnt != ZERO_CNT) && !flush;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {in_err, in_incpc, in_instr};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;

endmodule

// File: tb/tb_proc_fetch_queue.sv
// Directed bench for proc_fetch_queue: vector table plus hand-written reset and bypass sequences.
// Build with FETCH_QUEUE_BYPASS_EN defined to exercise the bypass path as well.
module tb_proc_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic [15:0] in_incpc;
  logic        in_err;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_incpc;
  logic        out_err;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  int tests_run = 0;
  int tests_failed = 0;

  proc_fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_incpc(in_incpc), .in_err(in_err),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_incpc(out_incpc), .out_err(out_err),
    .out_ready(out_ready), .flush(flush), .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] ii;
    logic        ie;
    logic        ordy;
    logic        fl;
    logic        e_ird;
    logic        e_ov;
    logic        chk;
    logic [15:0] e_instr;
    logic        e_err;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] pc_of(input logic [15:0] w);
    return w + 16'h0002;
  endfunction

  function automatic vec_t mk(input logic iv, input logic [15:0] ii, input logic ie,
                              input logic ordy, input logic fl, input logic e_ird,
                              input logic e_ov, input logic chk, input logic [15:0] e_instr,
                              input logic e_err, input logic [2:0] e_cnt);
    vec_t v;
    v.iv = iv; v.ii = ii; v.ie = ie; v.ordy = ordy; v.fl = fl;
    v.e_ird = e_ird; v.e_ov = e_ov; v.chk = chk;
    v.e_instr = e_instr; v.e_err = e_err; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] ii, input logic ie,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_instr  = ii;
    in_incpc  = pc_of(ii);
    in_err    = ie;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic check_head(input string tag, input logic [15:0] e_instr, input logic e_err);
    check({tag, ".out_instr"}, 32'(out_instr), 32'(e_instr));
    check({tag, ".out_incpc"}, 32'(out_incpc), 32'(pc_of(e_instr)));
    check({tag, ".out_err"}, 32'(out_err), 32'(e_err));
  endtask

  initial begin
    // fill: four words, then a fifth held against a full queue
    vecs.push_back(mk(1, 16'h1111, 0, 0, 0, 1, BYP, 0, 16'h0000, 0, 3'd0));
    vecs.push_back(mk(1, 16'h2222, 0, 0, 0, 1, 1,   1, 16'h1111, 0, 3'd1));
    vecs.push_back(mk(1, 16'h3333, 0, 0, 0, 1, 1,   1, 16'h1111, 0, 3'd2));
    vecs.push_back(mk(1, 16'h4444, 0, 0, 0, 1, 1,   1, 16'h1111, 0, 3'd3));
    vecs.push_back(mk(1, 16'h5555, 0, 0, 0, 0, 1,   1, 16'h1111, 0, 3'd4));
    // drain: no pop-through while full, then FIFO order
    vecs.push_back(mk(1, 16'h5555, 0, 1, 0, 0, 1,   1, 16'h1111, 0, 3'd4));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 1,   1, 16'h2222, 0, 3'd3));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 1,   1, 16'h3333, 0, 3'd2));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 1,   1, 16'h4444, 0, 3'd1));
    // empty; start the steady push/pop run at occupancy 2
    vecs.push_back(mk(1, 16'hA000, 0, 0, 0, 1, BYP, 0, 16'h0000, 0, 3'd0));
    vecs.push_back(mk(1, 16'hA001, 0, 0, 0, 1, 1,   1, 16'hA000, 0, 3'd1));
    for (int k = 0; k < 10; k++) begin
      vecs.push_back(mk(1, 16'hA002 + 16'(k), 0, 1, 0, 1, 1, 1, 16'hA000 + 16'(k), 0, 3'd2));
    end
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 1,   1, 16'hA00A, 0, 3'd2));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 1,   1, 16'hA00B, 0, 3'd1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 0,   0, 16'h0000, 0, 3'd0));
    // error flag travels with its word
    vecs.push_back(mk(1, 16'h0A0A, 1, 0, 0, 1, BYP, 0, 16'h0000, 0, 3'd0));
    vecs.push_back(mk(1, 16'h0B0B, 0, 0, 0, 1, 1,   1, 16'h0A0A, 1, 3'd1));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 1,   1, 16'h0A0A, 1, 3'd2));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 1,   1, 16'h0B0B, 0, 3'd1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 0,   0, 16'h0000, 0, 3'd0));
    // flush at occupancy 3 with 0xBEEF presented; it must be dropped
    vecs.push_back(mk(1, 16'hC001, 0, 0, 0, 1, BYP, 0, 16'h0000, 0, 3'd0));
    vecs.push_back(mk(1, 16'hC002, 0, 0, 0, 1, 1,   1, 16'hC001, 0, 3'd1));
    vecs.push_back(mk(1, 16'hC003, 0, 0, 0, 1, 1,   1, 16'hC001, 0, 3'd2));
    vecs.push_back(mk(1, 16'hBEEF, 0, 0, 1, 0, 1,   1, 16'hC001, 0, 3'd3));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 0,   0, 16'h0000, 0, 3'd0));
    vecs.push_back(mk(1, 16'hD001, 0, 0, 0, 1, BYP, 0, 16'h0000, 0, 3'd0));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 1,   1, 16'hD001, 0, 3'd1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 0,   0, 16'h0000, 0, 3'd0));

    // reset state
    rst = 1'b0;
    drive(0, 16'h0000, 0, 0, 0);
    #2;
    check("reset.in_ready", 32'(in_ready), 32'd0);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.count", 32'(count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].ii, vecs[i].ie, vecs[i].ordy, vecs[i].fl);
      #1;
      check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ird));
      check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].e_cnt));
      if (vecs[i].chk) check_head($sformatf("v%0d", i), vecs[i].e_instr, vecs[i].e_err);
    end

    // asynchronous reset between edges at occupancy 2
    @(negedge clk);
    drive(1, 16'hE001, 0, 0, 0);
    @(negedge clk);
    drive(1, 16'hE002, 0, 0, 0);
    @(negedge clk);
    drive(0, 16'h0000, 0, 0, 0);
    #1;
    check("arst.pre_count", 32'(count), 32'd2);
    check("arst.pre_valid", 32'(out_valid), 32'd1);
    check_head("arst.pre", 16'hE001, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.count", 32'(count), 32'd0);
    check("arst.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst.rel_in_ready", 32'(in_ready), 32'd1);
    check("arst.rel_count", 32'(count), 32'd0);
    check("arst.rel_out_valid", 32'(out_valid), 32'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // words forwarded through the empty queue in the same cycle, never stored
    @(negedge clk);
    drive(1, 16'h0A0A, 1, 1, 0);
    #1;
    check("byp0.out_valid", 32'(out_valid), 32'd1);
    check_head("byp0", 16'h0A0A, 1'b1);
    check("byp0.count", 32'(count), 32'd0);
    @(negedge clk);
    drive(1, 16'h0B0B, 0, 1, 0);
    #1;
    check("byp1.out_valid", 32'(out_valid), 32'd1);
    check_head("byp1", 16'h0B0B, 1'b0);
    check("byp1.count", 32'(count), 32'd0);
    @(negedge clk);
    drive(0, 16'h0000, 0, 0, 0);
    #1;
    check("byp2.out_valid", 32'(out_valid), 32'd0);
    check("byp2.count", 32'(count), 32'd0);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
